// File: rtl/line_window_buffer.sv
// Streaming 3x3 window generator: two line stores plus a 3x3 shift register turn a
// raster pixel stream into one window per pixel once two full rows and columns exist.
module line_window_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int LINE_WIDTH = 640,
  parameter int CHECK_LEN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   pixel_in,
  input  logic                    pixel_valid,
  input  logic                    pixel_sof,
  input  logic                    pixel_eol,
  output logic [9*DATA_WIDTH-1:0] win_out,
  output logic                    win_valid,
  output logic                    win_sof,
  output logic                    win_eol,
  output logic                    err_line_len
);

  localparam int            CW        = $clog2(LINE_WIDTH);
  localparam logic [CW-1:0] LAST_COL  = CW'(LINE_WIDTH - 1);
  localparam logic [CW-1:0] MIN_COL   = CW'(2);
  localparam logic [1:0]    FULL_ROW  = 2'd2;

  // Input stream: a beat is transferred on every cycle pixel_valid is high; there is
  // no ready, so the block must absorb one beat per cycle. Output windows are
  // qualified by win_valid alone and are never stalled.

  logic [CW-1:0]         col;
  logic [1:0]            row;
  logic                  first_beat;
  logic                  frame_head;
  logic                  err;
  logic [DATA_WIDTH-1:0] line0 [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] line1 [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] win   [3][3];

  logic                   start;
  logic [CW-1:0]          cur_col;
  logic [1:0]             cur_row;
  logic                   at_last;
  logic                   wrap;
  logic                   len_bad;
  logic                   emit;
  logic [DATA_WIDTH-1:0]  up2;
  logic [DATA_WIDTH-1:0]  up1;
  logic [CW-1:0]          col_next;
  logic [1:0]             row_next;
  logic                   err_next;
  logic                   head_next;
  logic [DATA_WIDTH-1:0]  win_next [3][3];
  logic [9*DATA_WIDTH-1:0] win_pack;

  always_comb begin
    // A sof beat, or the first beat after reset, is forced to position (0,0).
    start    = pixel_sof | first_beat;
    cur_col  = start ? '0 : col;
    cur_row  = start ? 2'd0 : row;
    at_last  = (cur_col == LAST_COL);
    wrap     = pixel_eol | at_last;
    len_bad  = pixel_eol ^ at_last;
    emit     = pixel_valid & (cur_row == FULL_ROW) & (cur_col >= MIN_COL);
    up2      = line1[cur_col];
    up1      = line0[cur_col];
    col_next = wrap ? '0 : cur_col + CW'(1);
    row_next = (wrap && (cur_row != FULL_ROW)) ? cur_row + 2'd1 : cur_row;
    err_next = ((start ? 1'b0 : err) | len_bad) & (CHECK_LEN != 0);
    head_next = emit ? 1'b0 : (start | frame_head);

    for (int i = 0; i < 3; i++) begin
      win_next[i][0] = win[i][1];
      win_next[i][1] = win[i][2];
    end
    win_next[0][2] = up2;
    win_next[1][2] = up1;
    win_next[2][2] = pixel_in;

    win_pack = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_pack[(3*i+j)*DATA_WIDTH +: DATA_WIDTH] = win_next[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= 2'd0;
      first_beat <= 1'b1;
      frame_head <= 1'b0;
      err        <= 1'b0;
      win_out    <= '0;
      win_valid  <= 1'b0;
      win_sof    <= 1'b0;
      win_eol    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= '0;
        end
      end
    end else begin
      win_valid <= emit;
      win_sof   <= emit & frame_head;
      win_eol   <= emit & wrap;
      if (pixel_valid) begin
        col        <= col_next;
        row        <= row_next;
        first_beat <= 1'b0;
        frame_head <= head_next;
        err        <= err_next;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            win[i][j] <= win_next[i][j];
          end
        end
        // win_out only changes when a window is actually emitted.
        if (emit) begin
          win_out <= win_pack;
        end
      end
    end
  end

  // Line stores carry no reset so they can map onto block RAM.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      line1[cur_col] <= line0[cur_col];
      line0[cur_col] <= pixel_in;
    end
  end

  assign err_line_len = err;

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer with LINE_WIDTH=4: directed frames, a position-based
// window model checked every cycle, and hand-computed window literals.
module tb_line_window_buffer;

  localparam int DW = 12;
  localparam int LW = 4;
  localparam int WW = 9 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_sof = 1'b0;
  logic          pixel_eol = 1'b0;
  logic [WW-1:0] win_out;
  logic          win_valid;
  logic          win_sof;
  logic          win_eol;
  logic          err_line_len;

  line_window_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .CHECK_LEN(1)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_sof(pixel_sof), .pixel_eol(pixel_eol), .win_out(win_out),
    .win_valid(win_valid), .win_sof(win_sof), .win_eol(win_eol),
    .err_line_len(err_line_len)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] cap_q[$];
  bit            cap_sof[$];
  bit            cap_eol[$];
  int            b2b = 0;
  bit            prev_v = 1'b0;

  task automatic chk(string name, logic [WW-1:0] act, logic [WW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [WW-1:0] mk(int p0, int p1, int p2, int p3, int p4,
                                       int p5, int p6, int p7, int p8);
    logic [WW-1:0] r;
    r = {DW'(p8), DW'(p7), DW'(p6), DW'(p5), DW'(p4), DW'(p3), DW'(p2), DW'(p1), DW'(p0)};
    return r;
  endfunction

  function automatic int centre(logic [WW-1:0] w);
    return int'(w[4*DW +: DW]);
  endfunction

  // ---------------- behavioural model ----------------
  // Frame kept as a 2-D picture by absolute row; a window is the 3x3 patch ending at
  // the current pixel. Patches touching never-written pixels are not value-checked.
  logic [DW-1:0] pix [16][LW];
  bit            pk  [16][LW];
  int            m_row = 0;
  int            m_col = 0;
  bit            m_first = 1'b1;
  bit            m_need_sof = 1'b0;
  bit            exp_valid = 1'b0, exp_sof = 1'b0, exp_eol = 1'b0, exp_err = 1'b0;
  logic [WW-1:0] exp_win = '0;
  bit            exp_known = 1'b1;

  task automatic model_reset();
    m_first = 1'b1; m_row = 0; m_col = 0; m_need_sof = 1'b0;
    exp_valid = 1'b0; exp_sof = 1'b0; exp_eol = 1'b0; exp_err = 1'b0;
    exp_win = '0; exp_known = 1'b1;
  endtask

  task automatic model_beat(bit v, int d, bit s, bit e);
    bit last;
    exp_valid = 1'b0; exp_sof = 1'b0; exp_eol = 1'b0;
    if (!v) return;
    if (s || m_first) begin
      m_row = 0; m_col = 0; m_first = 1'b0; exp_err = 1'b0; m_need_sof = 1'b1;
      for (int r = 0; r < 16; r++) for (int c = 0; c < LW; c++) pk[r][c] = 1'b0;
    end
    pix[m_row][m_col] = DW'(d);
    pk[m_row][m_col]  = 1'b1;
    last = (m_col == LW - 1);
    if (e != last) exp_err = 1'b1;
    if (m_row >= 2 && m_col >= 2) begin
      exp_valid = 1'b1;
      exp_sof = m_need_sof;
      m_need_sof = 1'b0;
      exp_eol = e || last;
      exp_known = 1'b1;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          exp_win[(3*i+j)*DW +: DW] = pix[m_row-2+i][m_col-2+j];
          if (!pk[m_row-2+i][m_col-2+j]) exp_known = 1'b0;
        end
      end
    end
    if (e || last) begin
      m_col = 0;
      if (m_row < 15) m_row++;
    end else begin
      m_col++;
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("win_valid", win_valid, exp_valid);
      chk("win_sof", win_sof, exp_sof);
      chk("win_eol", win_eol, exp_eol);
      chk("err_line_len", err_line_len, exp_err);
      if (exp_known) chk("win_out", win_out, exp_win);
      if (win_valid) begin
        if (prev_v) b2b++;
        cap_q.push_back(win_out);
        cap_sof.push_back(win_sof);
        cap_eol.push_back(win_eol);
      end
      prev_v = win_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(bit v, int d, bit s, bit e);
    @(posedge clk);
    #2;
    pixel_valid = v;
    pixel_in    = DW'(d);
    pixel_sof   = s;
    pixel_eol   = e;
    model_beat(v, d, s, e);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(int base, int rows, bit toggle, bit use_sof);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < LW; c++) begin
        step(1'b1, base + 10*r + c, use_sof && r == 0 && c == 0, c == LW - 1);
        // Garbage sof/eol on idle cycles must be ignored.
        if (toggle) step(1'b0, 12'hfff, 1'b1, 1'b1);
      end
    end
  endtask

  task automatic clear_caps();
    cap_q.delete(); cap_sof.delete(); cap_eol.delete();
    b2b = 0;
  endtask

  task automatic check_frame_a(string tag);
    chk({tag, "_count"}, cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk({tag, "_first_sof"}, cap_sof[0], 1);
      chk({tag, "_first_centre"}, centre(cap_q[0]), 11);
      chk({tag, "_second_eol"}, cap_eol[1], 1);
      chk({tag, "_second_centre"}, centre(cap_q[1]), 12);
      for (int k = 0; k < 4; k++) chk({tag, "_win_lit"}, cap_q[k], exp_q[k]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int r = 0; r < 16; r++) for (int c = 0; c < LW; c++) begin
      pix[r][c] = '0; pk[r][c] = 1'b0;
    end
    model_reset();
    exp_q.push_back(mk(0, 1, 2, 10, 11, 12, 20, 21, 22));
    exp_q.push_back(mk(1, 2, 3, 11, 12, 13, 21, 22, 23));
    exp_q.push_back(mk(10, 11, 12, 20, 21, 22, 30, 31, 32));
    exp_q.push_back(mk(11, 12, 13, 21, 22, 23, 31, 32, 33));

    #3;
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_sof", win_sof, 0);
    chk("rst_win_eol", win_eol, 0);
    chk("rst_err", err_line_len, 0);
    chk("rst_win_out", win_out, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    chk_en = 1'b1;

    // Contiguous 4x4 frame, pixel = 10*row+col.
    send_frame(0, 4, 1'b0, 1'b1);
    idle(3);
    check_frame_a("frame_a");
    clear_caps();

    // Same frame with pixel_valid toggling.
    send_frame(0, 4, 1'b1, 1'b1);
    idle(3);
    check_frame_a("toggle");
    chk("toggle_b2b", b2b, 0);
    clear_caps();

    // Short row 1 (eol at col 2) and a missing eol on row 3.
    for (int c = 0; c < LW; c++) step(1'b1, 100 + c, c == 0, c == LW - 1);
    for (int c = 0; c < 3; c++)  step(1'b1, 110 + c, 1'b0, c == 2);
    for (int c = 0; c < LW; c++) step(1'b1, 120 + c, 1'b0, c == LW - 1);
    for (int c = 0; c < LW; c++) step(1'b1, 130 + c, 1'b0, 1'b0);
    idle(3);
    chk("len_err_set", err_line_len, 1);
    chk("len_count", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk("len_first_centre", centre(cap_q[0]), 111);
      chk("len_last_eol", cap_eol[3], 1);
    end
    clear_caps();

    // sof arriving at (2,3) of a frame restarts tracking.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < LW; c++) step(1'b1, 200 + 10*r + c, r == 0 && c == 0, c == LW - 1);
    for (int c = 0; c < 3; c++) step(1'b1, 220 + c, 1'b0, 1'b0);
    send_frame(300, 3, 1'b0, 1'b1);
    idle(3);
    chk("midsof_count", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("midsof_old_sof", cap_sof[0], 1);
      chk("midsof_new_sof", cap_sof[1], 1);
      chk("midsof_new_centre", centre(cap_q[1]), 311);
      chk("midsof_new_eol", cap_eol[2], 1);
    end
    chk("midsof_err_clear", err_line_len, 0);
    clear_caps();

    // Reset pulsed in row 2 after a window was emitted.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < LW; c++) step(1'b1, 400 + 10*r + c, r == 0 && c == 0, c == LW - 1);
    for (int c = 0; c < 3; c++) step(1'b1, 420 + c, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #4;
    chk_en = 1'b0;
    pixel_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_win_valid", win_valid, 0);
    chk("arst_win_sof", win_sof, 0);
    chk("arst_win_eol", win_eol, 0);
    chk("arst_win_out", win_out, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    clear_caps();
    prev_v = 1'b0;
    chk_en = 1'b1;
    // First beat carries no sof: it must still be taken as (0,0).
    send_frame(500, 4, 1'b0, 1'b0);
    idle(3);
    chk("post_rst_count", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk("post_rst_sof", cap_sof[0], 1);
      chk("post_rst_last", cap_q[3], mk(511, 512, 513, 521, 522, 523, 531, 532, 533));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
